lsu_addr_gen: RTL and testbench

LSU_ADDR_GEN -- requirements
Module: lsu_addr_gen

---
 rtl/lsu_addr_gen_if.sv | 12 +
 rtl/lsu_addr_gen.sv | 113 +++++++++++
 tb/tb_lsu_addr_gen.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_addr_gen_if.sv
// Valid/ack data channel used on every port of lsu_addr_gen.
// A transfer happens in any cycle where valid and ack are both high.
interface data_interface #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ack;
    logic [WIDTH-1:0] data;

    modport producer (output valid, output data, input ack);
    modport consumer (input valid, input data, output ack);
endinterface

// File: rtl/lsu_addr_gen.sv
// Strided address generator: turns one {count, opcode} command with base/stride
// into count (op, address) token pairs for a downstream load/store unit.
//
// state | meaning
// IDLE  | waiting for cmd, base and stride to be valid together
// ISSUE | presenting element tokens until remaining reaches zero
module lsu_addr_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 2
) (
    input  logic            clock,
    input  logic            resetn,
    data_interface.consumer cmd,
    data_interface.consumer base,
    data_interface.consumer stride,
    data_interface.producer op,
    data_interface.producer address,
    output logic            busy
);
    localparam int CNT_WIDTH = DATA_WIDTH - OP_WIDTH;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                state;
    state_t                state_next;
    logic [OP_WIDTH-1:0]   opcode_q;
    logic [DATA_WIDTH-1:0] stride_q;
    logic [DATA_WIDTH-1:0] cur_addr_q;
    logic [CNT_WIDTH-1:0]  remaining_q;
    logic                  op_valid_q;
    logic                  addr_valid_q;
    logic [CNT_WIDTH-1:0]  cmd_count;
    logic                  ack_all;
    logic                  start;
    logic                  elem_done;
    logic                  last_elem;

    assign cmd_count = cmd.data[DATA_WIDTH-1:OP_WIDTH];
    assign start     = ack_all & (cmd_count != '0);
    // An element is finished once each side is either already taken or taken now.
    assign elem_done = (state == ISSUE) & (~op_valid_q | op.ack) & (~addr_valid_q | address.ack);
    assign last_elem = (remaining_q == CNT_WIDTH'(1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ack_all    = 1'b0;
        case (state)
            IDLE: begin
                if (resetn && cmd.valid && base.valid && stride.valid) begin
                    ack_all = 1'b1;
                    if (cmd_count != '0) begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (elem_done && last_elem) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            opcode_q     <= '0;
            stride_q     <= '0;
            cur_addr_q   <= '0;
            remaining_q  <= '0;
            op_valid_q   <= 1'b0;
            addr_valid_q <= 1'b0;
        end else if (start) begin
            opcode_q     <= cmd.data[OP_WIDTH-1:0];
            stride_q     <= stride.data;
            cur_addr_q   <= base.data;
            remaining_q  <= cmd_count;
            op_valid_q   <= 1'b1;
            addr_valid_q <= 1'b1;
        end else if (elem_done) begin
            if (last_elem) begin
                op_valid_q   <= 1'b0;
                addr_valid_q <= 1'b0;
            end else begin
                remaining_q  <= remaining_q - CNT_WIDTH'(1);
                cur_addr_q   <= cur_addr_q + stride_q;
                op_valid_q   <= 1'b1;
                addr_valid_q <= 1'b1;
            end
        end else begin
            op_valid_q   <= op_valid_q & ~op.ack;
            addr_valid_q <= addr_valid_q & ~address.ack;
        end
    end

    assign cmd.ack       = ack_all;
    assign base.ack      = ack_all;
    assign stride.ack    = ack_all;
    assign op.valid      = op_valid_q;
    assign op.data       = {{CNT_WIDTH{1'b0}}, opcode_q};
    assign address.valid = addr_valid_q;
    assign address.data  = cur_addr_q;
    assign busy          = (state == ISSUE);

endmodule

// File: tb/tb_lsu_addr_gen.sv
// Self-checking bench for lsu_addr_gen: directed vector table, multi-cycle
// corner sequences, and random backpressure against a queue-based model.
module tb_lsu_addr_gen;
    localparam int DW = 32;
    localparam int OW = 2;

    typedef enum int {ACK_ON, ACK_OFF, ACK_RAND} ack_mode_t;

    typedef struct {
        logic [DW-OW-1:0] cnt;
        logic [OW-1:0]    opc;
        logic [DW-1:0]    b;
        logic [DW-1:0]    s;
        int               exp_tok;
        logic [DW-1:0]    exp_last;
    } vec_t;

    logic clock  = 1'b0;
    logic resetn = 1'b1;
    logic busy;

    data_interface #(.WIDTH(DW)) cmd_if ();
    data_interface #(.WIDTH(DW)) base_if ();
    data_interface #(.WIDTH(DW)) stride_if ();
    data_interface #(.WIDTH(DW)) op_if ();
    data_interface #(.WIDTH(DW)) addr_if ();

    lsu_addr_gen #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .cmd     (cmd_if),
        .base    (base_if),
        .stride  (stride_if),
        .op      (op_if),
        .address (addr_if),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    int            n_checks    = 0;
    int            n_pass      = 0;
    ack_mode_t     op_mode     = ACK_ON;
    ack_mode_t     addr_mode   = ACK_ON;
    logic [DW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_op_q[$];
    int            tok_op      = 0;
    int            tok_addr    = 0;
    int            busy_cycles = 0;
    logic [DW-1:0] last_addr   = '0;
    logic          op_stall    = 1'b0;
    logic          addr_stall  = 1'b0;
    logic [DW-1:0] op_hold     = '0;
    logic [DW-1:0] addr_hold   = '0;

    function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    function automatic logic pick(input ack_mode_t m);
        case (m)
            ACK_ON:  return 1'b1;
            ACK_OFF: return 1'b0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Downstream ack driver
    initial begin
        op_if.ack   = 1'b0;
        addr_if.ack = 1'b0;
        forever begin
            @(posedge clock);
            #3;
            op_if.ack   = pick(op_mode);
            addr_if.ack = pick(addr_mode);
        end
    end

    // Token monitor on the falling edge: a transfer happens at the next rising edge
    initial begin
        forever begin
            @(negedge clock);
            if (!resetn) begin
                op_stall   = 1'b0;
                addr_stall = 1'b0;
            end else begin
                if (busy) busy_cycles++;
                if (op_stall) begin
                    chk("op_stall_valid", 32'(op_if.valid), 32'd1);
                    chk("op_stall_data", op_if.data, op_hold);
                end
                if (addr_stall) begin
                    chk("addr_stall_valid", 32'(addr_if.valid), 32'd1);
                    chk("addr_stall_data", addr_if.data, addr_hold);
                end
                if (op_if.valid && op_if.ack) begin
                    tok_op++;
                    chk("op_token_expected", 32'(exp_op_q.size() != 0), 32'd1);
                    if (exp_op_q.size() != 0) chk("op_data", op_if.data, exp_op_q.pop_front());
                end
                if (addr_if.valid && addr_if.ack) begin
                    tok_addr++;
                    last_addr = addr_if.data;
                    chk("addr_token_expected", 32'(exp_addr_q.size() != 0), 32'd1);
                    if (exp_addr_q.size() != 0) chk("addr_data", addr_if.data, exp_addr_q.pop_front());
                end
                op_stall   = op_if.valid && !op_if.ack;
                op_hold    = op_if.data;
                addr_stall = addr_if.valid && !addr_if.ack;
                addr_hold  = addr_if.data;
            end
        end
    end

    // Present a command and hold it until accepted; acks are expected exactly
    // when the model has no outstanding elements.
    task automatic send_cmd(input logic [DW-OW-1:0] cnt, input logic [OW-1:0] opc,
                            input logic [DW-1:0] b, input logic [DW-1:0] s);
        logic accepted;
        logic ack_bad;
        logic exp_ack;
        accepted = 1'b0;
        ack_bad  = 1'b0;
        @(posedge clock);
        #1;
        cmd_if.data     = {cnt, opc};
        base_if.data    = b;
        stride_if.data  = s;
        cmd_if.valid    = 1'b1;
        base_if.valid   = 1'b1;
        stride_if.valid = 1'b1;
        for (int i = 0; i < 300 && !accepted; i++) begin
            #1;
            exp_ack = (exp_addr_q.size() == 0) && (exp_op_q.size() == 0);
            if (!ack_bad) begin
                chk("ack_all", {29'd0, cmd_if.ack, base_if.ack, stride_if.ack}, {29'd0, {3{exp_ack}}});
                if ({cmd_if.ack, base_if.ack, stride_if.ack} !== {3{exp_ack}}) ack_bad = 1'b1;
            end
            accepted = cmd_if.ack;
            @(posedge clock);
            #1;
        end
        if (!accepted) chk("cmd_accept_timeout", 32'(cmd_if.ack), 32'd1);
        for (int k = 0; k < int'(cnt); k++) begin
            logic [63:0] t;
            t = 64'(b) + 64'(k) * 64'(s);
            exp_addr_q.push_back(t[DW-1:0]);
            exp_op_q.push_back(DW'(opc));
        end
        cmd_if.valid    = 1'b0;
        base_if.valid   = 1'b0;
        stride_if.valid = 1'b0;
        cmd_if.data     = $urandom;
        base_if.data    = $urandom;
        stride_if.data  = $urandom;
        #1;
        if (accepted) begin
            chk("first_latency", {29'd0, op_if.valid, addr_if.valid, busy}, (cnt != 0) ? 32'd7 : 32'd0);
            if (cnt != 0) chk("first_addr", addr_if.data, b);
        end
    endtask

    task automatic wait_idle(input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clock);
            #2;
            done = !busy && (exp_addr_q.size() == 0) && (exp_op_q.size() == 0);
        end
        if (!done) chk("drain_timeout_busy", 32'(busy), 32'd0);
        chk("model_drained", 32'(exp_addr_q.size() + exp_op_q.size()), 32'd0);
    endtask

    vec_t vecs[5];

    initial begin
        int t_op, t_addr, t_busy;
        longint total;

        vecs[0] = '{30'd3, 2'd2, 32'h0000_0010, 32'h0000_0001, 3, 32'h0000_0012};
        vecs[1] = '{30'd0, 2'd3, 32'h0000_0055, 32'h0000_0007, 0, 32'h0000_0000};
        vecs[2] = '{30'd2, 2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 2, 32'h0000_0001};
        vecs[3] = '{30'd4, 2'd0, 32'h0000_0100, 32'hFFFF_FFFC, 4, 32'h0000_00F4};
        vecs[4] = '{30'd1, 2'd3, 32'h0000_0ABC, 32'h0000_0005, 1, 32'h0000_0ABC};

        cmd_if.valid    = 1'b1;
        base_if.valid   = 1'b1;
        stride_if.valid = 1'b1;
        cmd_if.data     = 32'h0000_0016;
        base_if.data    = 32'h1234_5678;
        stride_if.data  = 32'h0000_0004;
        #1 resetn = 1'b0;
        #2;
        chk("reset_ctrl", {26'd0, op_if.valid, addr_if.valid, busy, cmd_if.ack, base_if.ack, stride_if.ack}, 32'd0);
        chk("reset_addr_data", addr_if.data, 32'd0);
        chk("reset_op_data", op_if.data, 32'd0);
        cmd_if.valid    = 1'b0;
        base_if.valid   = 1'b0;
        stride_if.valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;

        // Only two of three inputs valid: nothing may be acked
        @(posedge clock);
        #1;
        cmd_if.valid = 1'b1;
        base_if.valid = 1'b1;
        #1;
        chk("partial_valid_no_ack", {29'd0, cmd_if.ack, base_if.ack, stride_if.ack}, 32'd0);
        cmd_if.valid = 1'b0;
        base_if.valid = 1'b0;

        foreach (vecs[v]) begin
            t_op   = tok_op;
            t_addr = tok_addr;
            t_busy = busy_cycles;
            send_cmd(vecs[v].cnt, vecs[v].opc, vecs[v].b, vecs[v].s);
            wait_idle(100);
            chk($sformatf("vec%0d_addr_tokens", v), 32'(tok_addr - t_addr), 32'(vecs[v].exp_tok));
            chk($sformatf("vec%0d_op_tokens", v), 32'(tok_op - t_op), 32'(vecs[v].exp_tok));
            chk($sformatf("vec%0d_busy_cycles", v), 32'(busy_cycles - t_busy), 32'(vecs[v].exp_tok));
            if (vecs[v].exp_tok > 0) chk($sformatf("vec%0d_last_addr", v), last_addr, vecs[v].exp_last);
        end

        // op accepted two cycles ahead of address
        t_op   = tok_op;
        t_addr = tok_addr;
        op_mode   = ACK_ON;
        addr_mode = ACK_OFF;
        send_cmd(30'd2, 2'd1, 32'h0000_0200, 32'h0000_0004);
        @(posedge clock);
        #2;
        chk("split_op_dropped", {30'd0, op_if.valid, addr_if.valid}, 32'd1);
        chk("split_addr_held", addr_if.data, 32'h0000_0200);
        @(posedge clock);
        #2;
        chk("split_op_still_low", {30'd0, op_if.valid, addr_if.valid}, 32'd1);
        addr_mode = ACK_ON;
        @(posedge clock);
        #2;
        chk("split_second_elem", {30'd0, op_if.valid, addr_if.valid}, 32'd3);
        chk("split_second_addr", addr_if.data, 32'h0000_0204);
        chk("split_mid_tokens", 32'((tok_op - t_op) * 16 + (tok_addr - t_addr)), 32'h11);
        wait_idle(50);
        chk("split_op_tokens", 32'(tok_op - t_op), 32'd2);
        chk("split_addr_tokens", 32'(tok_addr - t_addr), 32'd2);

        // Reset during the second element of a five-element command
        t_addr = tok_addr;
        t_op   = tok_op;
        send_cmd(30'd5, 2'd2, 32'h0000_0040, 32'h0000_0008);
        @(posedge clock);
        #1;
        chk("pre_reset_second_addr", addr_if.data, 32'h0000_0048);
        cmd_if.valid    = 1'b1;
        base_if.valid   = 1'b1;
        stride_if.valid = 1'b1;
        cmd_if.data     = 32'h0000_0007;
        resetn = 1'b0;
        #1;
        chk("midreset_ctrl", {26'd0, op_if.valid, addr_if.valid, busy, cmd_if.ack, base_if.ack, stride_if.ack}, 32'd0);
        chk("midreset_addr_data", addr_if.data, 32'd0);
        exp_addr_q.delete();
        exp_op_q.delete();
        repeat (2) @(posedge clock);
        #1;
        cmd_if.valid    = 1'b0;
        base_if.valid   = 1'b0;
        stride_if.valid = 1'b0;
        resetn = 1'b1;
        repeat (4) @(posedge clock);
        #2;
        chk("post_reset_idle", {30'd0, busy, addr_if.valid}, 32'd0);
        chk("post_reset_tokens", 32'((tok_addr - t_addr) * 16 + (tok_op - t_op)), 32'h11);
        send_cmd(30'd2, 2'd3, 32'h0000_0080, 32'h0000_0010);
        wait_idle(50);
        chk("post_reset_cmd_tokens", 32'(tok_addr - t_addr), 32'd3);
        chk("post_reset_cmd_last", last_addr, 32'h0000_0090);

        // Random commands, back to back, with random downstream backpressure
        t_op   = tok_op;
        t_addr = tok_addr;
        total  = 0;
        op_mode   = ACK_RAND;
        addr_mode = ACK_RAND;
        for (int n = 0; n < 1000; n++) begin
            logic [DW-OW-1:0] cnt;
            cnt = DW-OW'($urandom_range(0, 8));
            total += longint'(cnt);
            send_cmd(cnt, OW'($urandom_range(0, 3)), $urandom, $urandom);
        end
        wait_idle(500);
        chk("rand_op_tokens", 32'(tok_op - t_op), 32'(total));
        chk("rand_addr_tokens", 32'(tok_addr - t_addr), 32'(total));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
